signed_bcd_converter: RTL

- Sequential binary-to-BCD stage that feeds the dual seven-segment display driver.
- Takes a two's-complement value and produces a sign flag plus hundreds/tens/ones BCD digits, ready for direct digit decode.
- Iterative shift-and-add-3 (double dabble): one bit per clock, start/busy/done handshake.

---
 rtl/signed_bcd_pkg.sv | 31 +++
 rtl/bcd_add3.sv | 27 ++
 rtl/signed_bcd_converter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/signed_bcd_pkg.sv
// -----------------------------------------------------------------------------
// signed_bcd_pkg
// Shared types and constants for the signed binary-to-BCD converter.
//   state_t        : converter FSM states (IDLE, SHIFT)
//   BCD_DIGIT_W    : bits per BCD digit
//   NUM_DIGITS     : number of BCD digits produced (hundreds, tens, ones)
//   SAT_LIMIT      : largest magnitude shown unsaturated when
//                    SIGNED_BCD_SAT_EN is defined
//   bcd_exceeds_limit : true when a three-digit BCD value is above SAT_LIMIT
// -----------------------------------------------------------------------------
package signed_bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int NUM_DIGITS  = 3;
    localparam int SAT_LIMIT   = 99;

    // Decimal value of the packed {hundreds, tens, ones} word compared to SAT_LIMIT.
    function automatic logic bcd_exceeds_limit(input logic [11:0] bcd);
        logic [9:0] dec;
        dec = ({6'd0, bcd[11:8]} * 10'd100)
            + ({6'd0, bcd[7:4]}  * 10'd10)
            +  {6'd0, bcd[3:0]};
        return (dec > 10'(SAT_LIMIT));
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble correction cell: a BCD digit of 5 or more gets
// 3 added so that the following left shift carries correctly into the next
// decimal digit.
// Ports:
//   i_digit : BCD digit before correction
//   o_digit : corrected digit (i_digit + 3 when i_digit >= 5)
// -----------------------------------------------------------------------------
module bcd_add3
    import signed_bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    // Add-3 correction for digits that would exceed 9 after doubling.
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end else begin
            o_digit = i_digit;
        end
    end

endmodule

// File: rtl/signed_bcd_converter.sv
// -----------------------------------------------------------------------------
// signed_bcd_converter
// Iterative (one bit per clock) two's-complement to sign + three-digit BCD
// converter using shift-and-add-3. A conversion is accepted on a rising edge
// with start=1 while idle and completes WIDTH edges later with a one-cycle
// done pulse; result registers hold until the next completion.
// Optional macro SIGNED_BCD_SAT_EN: magnitudes above 99 are shown as 99 and
// flag ovf (sign keeps the true sign). Without it ovf is always 0.
// Parameters:
//   WIDTH    : operand width, 4..10
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   start    : conversion request, honoured only while busy=0
//   value    : two's-complement operand, sampled on the accepting edge
//   busy     : conversion in progress
//   done     : one-cycle completion pulse
//   sign     : 1 = negative result (never set for zero)
//   hundreds : BCD hundreds digit
//   tens     : BCD tens digit
//   ones     : BCD ones digit
//   ovf      : saturation flag
// -----------------------------------------------------------------------------
module signed_bcd_converter
    import signed_bcd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             sign,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones,
    output logic             ovf
);

    localparam int BCD_W = BCD_DIGIT_W * NUM_DIGITS;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   w_mag_nxt;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_bcd_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               r_neg;
    logic               w_neg_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_sign;
    logic               w_sign_nxt;
    logic [3:0]         r_hundreds;
    logic [3:0]         w_hundreds_nxt;
    logic [3:0]         r_tens;
    logic [3:0]         w_tens_nxt;
    logic [3:0]         r_ones;
    logic [3:0]         w_ones_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;

    logic [WIDTH-1:0]   w_neg_value;
    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_shift_bcd;

    // Two's-complement negation; the most negative input maps to its
    // unsigned magnitude (e.g. -128 -> 128 for WIDTH=8).
    assign w_neg_value = ~value + {{(WIDTH-1){1'b0}}, 1'b1};

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .i_digit (r_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Corrected BCD accumulator shifted left with the next magnitude bit.
    assign w_shift_bcd = {w_adj[BCD_W-2:0], r_mag[WIDTH-1]};

    // Next-state and next-output logic for the converter FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_mag_nxt      = r_mag;
        w_bcd_nxt      = r_bcd;
        w_count_nxt    = r_count;
        w_neg_nxt      = r_neg;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_sign_nxt     = r_sign;
        w_hundreds_nxt = r_hundreds;
        w_tens_nxt     = r_tens;
        w_ones_nxt     = r_ones;
        w_ovf_nxt      = r_ovf;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SHIFT;
                    w_mag_nxt   = value[WIDTH-1] ? w_neg_value : value;
                    w_neg_nxt   = value[WIDTH-1];
                    w_bcd_nxt   = {BCD_W{1'b0}};
                    w_count_nxt = {CNT_W{1'b0}};
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_busy_nxt  = 1'b0;
                end
            end
            SHIFT: begin
                w_bcd_nxt   = w_shift_bcd;
                w_mag_nxt   = {r_mag[WIDTH-2:0], 1'b0};
                w_count_nxt = r_count + 4'd1;
                if (r_count == LAST_CNT) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    // A zero magnitude is never reported as negative.
                    w_sign_nxt  = r_neg & (|w_shift_bcd);
`ifdef SIGNED_BCD_SAT_EN
                    if (bcd_exceeds_limit(w_shift_bcd)) begin
                        w_hundreds_nxt = 4'd0;
                        w_tens_nxt     = 4'd9;
                        w_ones_nxt     = 4'd9;
                        w_ovf_nxt      = 1'b1;
                    end else begin
                        w_hundreds_nxt = w_shift_bcd[11:8];
                        w_tens_nxt     = w_shift_bcd[7:4];
                        w_ones_nxt     = w_shift_bcd[3:0];
                        w_ovf_nxt      = 1'b0;
                    end
`else
                    w_hundreds_nxt = w_shift_bcd[11:8];
                    w_tens_nxt     = w_shift_bcd[7:4];
                    w_ones_nxt     = w_shift_bcd[3:0];
                    w_ovf_nxt      = 1'b0;
`endif
                end else begin
                    w_busy_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_mag      <= {WIDTH{1'b0}};
            r_bcd      <= {BCD_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_neg      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sign     <= 1'b0;
            r_hundreds <= 4'd0;
            r_tens     <= 4'd0;
            r_ones     <= 4'd0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mag      <= w_mag_nxt;
            r_bcd      <= w_bcd_nxt;
            r_count    <= w_count_nxt;
            r_neg      <= w_neg_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_sign     <= w_sign_nxt;
            r_hundreds <= w_hundreds_nxt;
            r_tens     <= w_tens_nxt;
            r_ones     <= w_ones_nxt;
            r_ovf      <= w_ovf_nxt;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sign     = r_sign;
    assign hundreds = r_hundreds;
    assign tens     = r_tens;
    assign ones     = r_ones;
    assign ovf      = r_ovf;

endmodule
